muldiv_ctrl: RTL
================

Name: muldiv_ctrl

Overview:
Sequencer for the HI/LO register pair. Accepts one multiply/divide/move-to-HI/LO request at a time from the execute stage and runs it on a single-cycle-issue multiplier or an iterative 32-step divider. Drives the HI/LO write port: hi_data, lo_data, hi_write, lo_write. Raises busy so the pipeline stalls on a later HI/LO access.

Parameters:
DIV_STEPS, 32, divider iterations (one quotient bit per cycle); only 32 is legal

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
start  in  1  request valid; sampled only when busy=0
op  in  4  md_op_t operation code
a  in  32  rs operand (dividend / multiplicand / MTHI/MTLO data)
b  in  32  rt operand (divisor / multiplier)
flush  in  1  abort in-flight operation (exception / branch squash)
hi_in  in  32  current HI value (used by MADD family only)
lo_in  in  32  current LO value (used by MADD family only)
hi_data  out  32  HI write data
lo_data  out  32  LO write data
hi_write  out  1  HI write enable, one-cycle pulse
lo_write  out  1  LO write enable, one-cycle pulse
busy  out  1  high while state != IDLE
done  out  1  one-cycle pulse with the result write of MUL/DIV ops

Behaviour:
- Reset: state IDLE; hi_data, lo_data, hi_write, lo_write, busy and done all 0; divider registers cleared.
- States: IDLE, MUL, DIV, FIX.
- Accept: start=1 in IDLE. In any other state, start is ignored; the requester must hold start until busy=0.
- MTHI/MTLO: no state change; in the accept cycle, hi_write (or lo_write) = 1 and data = a, combinationally. done stays 0.
- MULT/MULTU: accept cycle registers the 64-bit product (signed or unsigned) and moves to MUL. The next cycle drives {hi_data, lo_data} = product with both writes = 1 and done = 1, then returns to IDLE. Write occurs at accept+1.
- DIV/DIVU: accept cycle latches operand magnitudes (signed ops use the absolute value), records sign_q = a[31]^b[31] and sign_r = a[31], and clears the step counter. State DIV runs restoring division, one bit per cycle, for cycles accept+1 .. accept+32. The counter is 5 bits and wraps 31 -> 0, moving to FIX. FIX applies sign fixups: quotient negated if sign_q, remainder negated if sign_r. It drives lo_data = quotient, hi_data = remainder, both writes = 1 and done = 1, then returns to IDLE. Write occurs at accept+33.
- Divide by zero (b == 0): no trap. Result is lo = 0xFFFFFFFF, hi = a (raw dividend), for both signed and unsigned ops. Latency is still 33 cycles.
- Overflow, DIV 0x80000000 / -1: lo = 0x80000000, hi = 0.
- Flush: has priority over everything. If asserted in any cycle, no write is issued that cycle and state returns to IDLE next cycle. A start in the same cycle as flush is dropped.
- Reset mid-operation: same as flush, and all outputs are 0 in the following cycle.
- Outputs hi_write/lo_write are 0 in every cycle not listed above.

Optional Feature:
MULDIV_MADD_EN
- Defined: ops MADD, MADDU, MSUB and MSUBU are legal. The accept cycle registers {hi_in, lo_in} +/- product, using signed or unsigned extension of the 64-bit product. The result is written at accept+1 like MULT.
- Undefined: these codes behave as a NOP; nothing is accepted, busy stays 0 and no write is issued.

Decomposition:
- Package muldiv_pkg holds:
  - md_op_t enum (4 bits): MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO, MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU.
  - md_state_t enum.
  - DIV_STEPS constant.
- Sub-module muldiv_divider: iterative restoring unsigned core. It has start/load, 32-bit magnitudes and a done flag, and is instantiated once. Sign handling and the FSM stay in muldiv_ctrl.

Test Plan:
- MULT a=0xFFFFFFFF b=2 -> at accept+1: hi=0xFFFFFFFF, lo=0xFFFFFFFE, both writes=1, done=1; MULTU same operands -> hi=0x1, lo=0xFFFFFFFE.
- DIVU a=100 b=7 -> busy for 33 cycles; at accept+33: lo=0xE, hi=0x2; DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV b=0 a=0x1234 -> at accept+33: lo=0xFFFFFFFF, hi=0x1234; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0xDEAD while IDLE -> same cycle hi_write=1, hi_data=0xDEAD, lo_write=0, busy stays 0; a second start while DIV is busy -> ignored, no extra write.
- DIVU started, flush at accept+10 -> IDLE at accept+11, no hi_write/lo_write through accept+40; resetn=0 mid-DIV -> all outputs 0 next cycle.
- (MULDIV_MADD_EN) hi_in=0, lo_in=5, MADD a=3 b=4 -> accept+1: hi=0, lo=17; MSUBU hi_in=0 lo_in=0 a=1 b=1 -> hi=0xFFFFFFFF, lo=0xFFFFFFFF.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

   // Divider iterations, one quotient bit per cycle; only 32 is legal.
   localparam int unsigned DIV_STEPS = 32;

   typedef enum logic [3:0] {
      MD_NONE  = 4'd0,
      MD_MULT  = 4'd1,
      MD_MULTU = 4'd2,
      MD_DIV   = 4'd3,
      MD_DIVU  = 4'd4,
      MD_MTHI  = 4'd5,
      MD_MTLO  = 4'd6,
      MD_MADD  = 4'd7,
      MD_MADDU = 4'd8,
      MD_MSUB  = 4'd9,
      MD_MSUBU = 4'd10
   } md_op_t;

   typedef enum logic [1:0] {
      StIdle,
      StMul,
      StDiv,
      StFix
   } md_state_t;

   function automatic logic [31:0] abs32(input logic [31:0] v);
      return v[31] ? -v : v;
   endfunction

endpackage

// File: rtl/muldiv_divider.sv
// Iterative restoring unsigned divider core: one quotient bit per step.
// load_i latches magnitudes and clears the step counter; done_o flags the final step.
module muldiv_divider
   import muldiv_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        load_i,
   input  logic        step_i,
   input  logic [31:0] dividend_i,
   input  logic [31:0] divisor_i,
   output logic [31:0] quotient_o,
   output logic [31:0] remainder_o,
   output logic        done_o
);

   logic [31:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [32:0] trial;

   // One restoring step: shift in the next dividend bit and try to subtract.
   always_comb begin
      quo_d = quo_q;
      rem_d = rem_q;
      dvs_d = dvs_q;
      cnt_d = cnt_q;
      trial = {rem_q, quo_q[31]} - {1'b0, dvs_q};
      if (load_i) begin
         quo_d = dividend_i;
         rem_d = '0;
         dvs_d = divisor_i;
         cnt_d = '0;
      end else if (step_i) begin
         if (!trial[32]) begin
            rem_d = trial[31:0];
            quo_d = {quo_q[30:0], 1'b1};
         end else begin
            rem_d = {rem_q[30:0], quo_q[31]};
            quo_d = {quo_q[30:0], 1'b0};
         end
         // 5-bit counter wraps 31 -> 0 on the last step
         cnt_d = cnt_q + 5'd1;
      end
   end

   // Divider state registers, cleared on reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         quo_q <= '0;
         rem_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
      end else begin
         quo_q <= quo_d;
         rem_q <= rem_d;
         dvs_q <= dvs_d;
         cnt_q <= cnt_d;
      end
   end

   assign quotient_o  = quo_q;
   assign remainder_o = rem_q;
   assign done_o      = step_i && (cnt_q == 5'(DIV_STEPS - 1));

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO sequencer: MTHI/MTLO, single-cycle-issue multiply, 32-step divide.
// Optional build macro MULDIV_MADD_EN enables MADD/MADDU/MSUB/MSUBU.
module muldiv_ctrl
   import muldiv_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        start_i,
   input  logic [3:0]  op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        flush_i,
   input  logic [31:0] hi_in_i,
   input  logic [31:0] lo_in_i,
   output logic [31:0] hi_data_o,
   output logic [31:0] lo_data_o,
   output logic        hi_write_o,
   output logic        lo_write_o,
   output logic        busy_o,
   output logic        done_o
);

   md_state_t   state_q, state_d;
   md_op_t      op;
   logic        is_mul, is_madd, is_div, is_mt, mul_signed, div_signed, legal, accept;
   logic [63:0] a_ext, b_ext, prod, prod_d, prod_q;
   logic        sign_q_q, sign_r_q, div0_q;
   logic [31:0] quotient, remainder, q_fix, r_fix;
   logic        div_done, div_load;

   assign op = md_op_t'(op_i);

`ifdef MULDIV_MADD_EN
   logic        is_msub;
   logic [63:0] acc;
   assign acc = {hi_in_i, lo_in_i};
`else
   logic        unused_acc;
   assign unused_acc = ^{hi_in_i, lo_in_i};
`endif

   // Decode the request and decide whether it is accepted this cycle.
   always_comb begin
      is_mul = (op == MD_MULT) || (op == MD_MULTU);
      is_div = (op == MD_DIV) || (op == MD_DIVU);
      is_mt  = (op == MD_MTHI) || (op == MD_MTLO);
`ifdef MULDIV_MADD_EN
      is_madd = op inside {MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU};
      is_msub = op inside {MD_MSUB, MD_MSUBU};
`else
      is_madd = 1'b0;
`endif
      mul_signed = op inside {MD_MULT, MD_MADD, MD_MSUB};
      div_signed = (op == MD_DIV);
      legal      = is_mul || is_madd || is_div || is_mt;
      accept     = resetn && !flush_i && start_i && (state_q == StIdle) && legal;
   end

   // 64-bit product, optionally accumulated into the current HI/LO pair.
   always_comb begin
      a_ext = mul_signed ? {{32{a_i[31]}}, a_i} : {32'd0, a_i};
      b_ext = mul_signed ? {{32{b_i[31]}}, b_i} : {32'd0, b_i};
      prod  = a_ext * b_ext;
`ifdef MULDIV_MADD_EN
      if (is_madd) prod_d = is_msub ? (acc - prod) : (acc + prod);
      else         prod_d = prod;
`else
      prod_d = prod;
`endif
   end

   assign div_load = accept && is_div;

   muldiv_divider u_divider (
      .clk         (clk),
      .resetn      (resetn),
      .load_i      (div_load),
      .step_i      (state_q == StDiv),
      .dividend_i  (div_signed ? abs32(a_i) : a_i),
      .divisor_i   (div_signed ? abs32(b_i) : b_i),
      .quotient_o  (quotient),
      .remainder_o (remainder),
      .done_o      (div_done)
   );

   // Divide by zero leaves the remainder holding |a|; sign fixup restores raw a.
   assign q_fix = div0_q ? 32'hFFFF_FFFF : (sign_q_q ? -quotient : quotient);
   assign r_fix = sign_r_q ? -remainder : remainder;

   // Next state and HI/LO write port; flush and reset suppress everything.
   always_comb begin
      state_d    = state_q;
      hi_data_o  = '0;
      lo_data_o  = '0;
      hi_write_o = 1'b0;
      lo_write_o = 1'b0;
      done_o     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (is_mt) begin
                  hi_write_o = (op == MD_MTHI);
                  lo_write_o = (op == MD_MTLO);
                  hi_data_o  = (op == MD_MTHI) ? a_i : '0;
                  lo_data_o  = (op == MD_MTLO) ? a_i : '0;
               end else if (is_div) begin
                  state_d = StDiv;
               end else begin
                  state_d = StMul;
               end
            end
         end
         StMul: begin
            {hi_data_o, lo_data_o} = prod_q;
            hi_write_o = 1'b1;
            lo_write_o = 1'b1;
            done_o     = 1'b1;
            state_d    = StIdle;
         end
         StDiv: begin
            if (div_done) state_d = StFix;
         end
         StFix: begin
            hi_data_o  = r_fix;
            lo_data_o  = q_fix;
            hi_write_o = 1'b1;
            lo_write_o = 1'b1;
            done_o     = 1'b1;
            state_d    = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (flush_i || !resetn) begin
         state_d    = StIdle;
         hi_data_o  = '0;
         lo_data_o  = '0;
         hi_write_o = 1'b0;
         lo_write_o = 1'b0;
         done_o     = 1'b0;
      end
   end

   // State, product and divide-sign registers.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q  <= StIdle;
         prod_q   <= '0;
         sign_q_q <= 1'b0;
         sign_r_q <= 1'b0;
         div0_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept && (is_mul || is_madd)) prod_q <= prod_d;
         if (div_load) begin
            sign_q_q <= div_signed && (a_i[31] ^ b_i[31]);
            sign_r_q <= div_signed && a_i[31];
            div0_q   <= (b_i == 32'd0);
         end
      end
   end

   assign busy_o = (state_q != StIdle);

endmodule
